// File: rtl/uart_rx_pkg.sv
// uart_pkg: shared UART types and baud helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t;
  function automatic int uart_period(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: received-word handshake plus error pulses
interface uart_rx_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] data;
  logic data_valid;
  logic data_ready;
  logic frame_err;
  logic overrun;
  modport master (output data, data_valid, frame_err, overrun, input data_ready);
  modport slave (input data, data_valid, frame_err, overrun, output data_ready);
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous input
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  // first flop catches metastability, second presents a settled level
  always_ff @(posedge clk) {m, q} <= rst ? {2{RST_VAL}} : {d, m};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver with valid/ready word output
module uart_rx import uart_pkg::*; #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input logic clk,
  input logic rst,
  input logic rx,
  uart_rx_if.master bus
);
  localparam int PERIOD = uart_period(CLK_FREQ, BAUD_RATE);
  localparam int HALF = PERIOD / 2;
  localparam int CW = $clog2(PERIOD + 1);
  localparam int BW = $clog2(DATA_BITS);
  uart_rx_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic rx_s, tick, deliver, ferr, take, drop;
  sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d(rx), .q(rx_s));
  assign tick = cnt == CW'(PERIOD - 1);
  // state register: rst mid-frame discards everything collected so far
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      shift <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bit_idx <= bit_idx_n;
      shift <= shift_n;
    end
  end
  // next state: half-bit start qualification, then one sample per bit period
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    bit_idx_n = bit_idx;
    shift_n = shift;
    deliver = 1'b0;
    ferr = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        state_n = rx_s ? IDLE : START;
      end
      START: if (cnt == CW'(HALF - 1)) begin
        cnt_n = '0;
        bit_idx_n = '0;
        state_n = rx_s ? IDLE : DATA;
      end
      DATA: if (tick) begin
        cnt_n = '0;
        shift_n[bit_idx] = rx_s;
        bit_idx_n = bit_idx == BW'(DATA_BITS - 1) ? '0 : bit_idx + 1'b1;
        state_n = bit_idx == BW'(DATA_BITS - 1) ? STOP : DATA;
      end
      STOP: if (tick) begin
        cnt_n = '0;
        ferr = !rx_s;
        deliver = rx_s && bit_idx == BW'(STOP_BITS - 1);
        bit_idx_n = rx_s ? bit_idx + 1'b1 : bit_idx;
        state_n = !rx_s ? BREAK : deliver ? IDLE : STOP;
      end
      BREAK: begin
        cnt_n = '0;
        state_n = rx_s ? IDLE : BREAK;
      end
      default: state_n = IDLE;
    endcase
  end
  // output decode: a finished word is taken if the slot is free or emptying now
  always_comb begin
    take = deliver && (!bus.data_valid || bus.data_ready);
    drop = deliver && bus.data_valid && !bus.data_ready;
  end
  // handshake register: hold word until transfer, pulse errors for one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.data <= '0;
      bus.data_valid <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      bus.data <= take ? shift : bus.data;
      bus.data_valid <= take || (bus.data_valid && !bus.data_ready);
      bus.frame_err <= ferr;
      bus.overrun <= drop;
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames with a scoreboard of expected words
module tb_uart_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx1 = 1'b1;
  logic rx2 = 1'b1;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int nvalid = 0;
  int nferr = 0;
  int novr = 0;
  int tv = 0;
  int t0 = 0;
  logic pv = 1'b0;
  logic px = 1'b0;
  logic [7:0] sbq[$];
  always #5 clk = ~clk;
  uart_rx_if #(.DATA_BITS(8)) b1 ();
  uart_rx_if #(.DATA_BITS(8)) b2 ();
  uart_rx #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .STOP_BITS(1))
    dut1 (.clk(clk), .rst(rst), .rx(rx1), .bus(b1));
  uart_rx #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .STOP_BITS(2))
    dut2 (.clk(clk), .rst(rst), .rx(rx2), .bus(b2));
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input bit sel, input logic [7:0] b, input int pt, input bit stop_ok, input int nstop);
    logic lv[12];
    int n;
    n = 9 + nstop;
    lv[0] = 1'b0;
    for (int i = 0; i < 8; i++) lv[i+1] = b[i];
    for (int i = 0; i < nstop; i++) lv[9+i] = stop_ok;
    for (int c = 0; c < (n * pt + 5) / 10; c++) begin
      if (sel) rx2 = lv[c*10/pt];
      else rx1 = lv[c*10/pt];
      @(negedge clk);
    end
    if (sel) rx2 = 1'b1;
    else rx1 = stop_ok;
  endtask
  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
      px = 1'b0;
    end else begin
      if (b1.data_valid && (!pv || px)) begin
        nvalid++;
        tv = cyc;
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $error("FAIL sb_unexpected: observed word %0h expected none", b1.data);
        end else chk("sb_data", 32'(b1.data), 32'(sbq.pop_front()));
      end
      if (b1.frame_err) nferr++;
      if (b1.overrun) novr++;
      if (b1.frame_err || b1.overrun) chk("err_exclusive", 32'(b1.frame_err & b1.overrun), 0);
      pv = b1.data_valid;
      px = b1.data_valid && b1.data_ready;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    b1.data_ready = 1'b0;
    b2.data_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(b1.data_valid), 0);
    chk("rst_data", 32'(b1.data), 0);
    chk("rst_ferr", 32'(b1.frame_err), 0);
    chk("rst_ovr", 32'(b1.overrun), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    sbq.push_back(8'hA5);
    t0 = cyc;
    send(0, 8'hA5, 100, 1, 1);
    repeat (20) @(negedge clk);
    chk("a5_latency", 32'(tv - t0), 98);
    chk("a5_held_valid", 32'(b1.data_valid), 1);
    chk("a5_held_data", 32'(b1.data), 32'hA5);
    b1.data_ready = 1'b1;
    @(negedge clk);
    chk("a5_drain", 32'(b1.data_valid), 0);
    sbq.push_back(8'h00);
    sbq.push_back(8'hFF);
    send(0, 8'h00, 100, 1, 1);
    send(0, 8'hFF, 100, 1, 1);
    repeat (10) @(negedge clk);
    chk("b2b_count", 32'(nvalid), 3);
    chk("b2b_ferr", 32'(nferr), 0);
    chk("b2b_ovr", 32'(novr), 0);
    rx1 = 1'b0;
    repeat (3) @(negedge clk);
    rx1 = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_count", 32'(nvalid), 3);
    chk("glitch_ferr", 32'(nferr), 0);
    chk("glitch_ovr", 32'(novr), 0);
    send(0, 8'h3C, 100, 0, 1);
    repeat (200) @(negedge clk);
    rx1 = 1'b1;
    repeat (20) @(negedge clk);
    chk("break_ferr", 32'(nferr), 1);
    chk("break_count", 32'(nvalid), 3);
    sbq.push_back(8'h81);
    send(0, 8'h81, 100, 1, 1);
    repeat (10) @(negedge clk);
    chk("after_break_count", 32'(nvalid), 4);
    b1.data_ready = 1'b0;
    sbq.push_back(8'h11);
    send(0, 8'h11, 100, 1, 1);
    send(0, 8'h22, 100, 1, 1);
    repeat (10) @(negedge clk);
    chk("ovr_pulses", 32'(novr), 1);
    chk("ovr_data_kept", 32'(b1.data), 32'h11);
    chk("ovr_valid", 32'(b1.data_valid), 1);
    chk("ovr_count", 32'(nvalid), 5);
    b1.data_ready = 1'b1;
    @(negedge clk);
    b1.data_ready = 1'b0;
    chk("ovr_drain", 32'(b1.data_valid), 0);
    fork
      send(0, 8'h55, 100, 1, 1);
      begin
        repeat (35) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", 32'(b1.data_valid), 0);
        chk("midrst_data", 32'(b1.data), 0);
        chk("midrst_ferr", 32'(b1.frame_err), 0);
        chk("midrst_ovr", 32'(b1.overrun), 0);
      end
    join
    rst = 1'b0;
    repeat (5) @(negedge clk);
    b1.data_ready = 1'b1;
    sbq.push_back(8'h66);
    send(0, 8'h66, 100, 1, 1);
    repeat (10) @(negedge clk);
    chk("post_rst_count", 32'(nvalid), 6);
    chk("post_rst_data", 32'(b1.data), 32'h66);
    send(1, 8'hA5, 100, 1, 2);
    for (int i = 0; i < 30 && !b2.data_valid; i++) @(negedge clk);
    chk("stop2_valid", 32'(b2.data_valid), 1);
    chk("stop2_data", 32'(b2.data), 32'hA5);
    b1.data_ready = 1'b0;
    sbq.push_back(8'hA5);
    send(0, 8'hA5, 97, 1, 1);
    repeat (10) @(negedge clk);
    chk("fast_data", 32'(b1.data), 32'hA5);
    b1.data_ready = 1'b1;
    @(negedge clk);
    b1.data_ready = 1'b0;
    sbq.push_back(8'hA5);
    send(0, 8'hA5, 103, 1, 1);
    repeat (10) @(negedge clk);
    chk("slow_data", 32'(b1.data), 32'hA5);
    chk("final_count", 32'(nvalid), 8);
    chk("final_ferr", 32'(nferr), 1);
    chk("final_ovr", 32'(novr), 1);
    chk("sb_drained", 32'(sbq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
